// File: rtl/dp_pkg.sv
// -----------------------------------------------------------------------------
// dp_pkg
// Shared definitions for the parametrised datapath:
//   - ALU operation encodings (alu_op_e)
//   - default widths used as parameter defaults by the top level
//   - instruction field offsets, derived from the operand width
//   - register-index width helper
// Instruction layout, MSB first: Opcode | Source1 | Source2 | Dest
// -----------------------------------------------------------------------------
package dp_pkg;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_MUL  = 2'd3
  } alu_op_e;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_OPCODE_WIDTH = 4;
  localparam int DEF_NUM_REGS     = 16;

  // Dest occupies the least significant operand field.
  localparam int DEST_LSB = 0;

  function automatic int src2_lsb(input int addr_width);
    return addr_width;
  endfunction

  function automatic int src1_lsb(input int addr_width);
    return 2 * addr_width;
  endfunction

  function automatic int opcode_lsb(input int addr_width);
    return 3 * addr_width;
  endfunction

  // A single-entry register file still needs a one-bit index vector.
  function automatic int reg_idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential ALU: PASS/ADD/SUB complete at the edge that samples i_start;
// MUL is a shift-add multiplier retiring one multiplier bit per edge for
// DATA_WIDTH edges. The result register and Z/N/V flags change only when an
// operation completes; o_done pulses for the cycle after completion.
//
// Ports:
//   Clk       in   clock, rising edge
//   Rst       in   synchronous active-high reset (aborts a multiply silently)
//   i_start   in   start request, ignored while o_busy
//   i_op      in   operation, sampled only with i_start
//   i_src1/2  in   operands (current register-file read ports)
//   o_result  out  last completed result
//   o_busy    out  multiply in progress
//   o_done    out  one-cycle completion pulse
//   o_z/n/v   out  zero / negative / signed-overflow flags
// -----------------------------------------------------------------------------
module alu_seq
  import dp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  i_start,
  input  alu_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_src1,
  input  logic [DATA_WIDTH-1:0] i_src2,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_z,
  output logic                  o_n,
  output logic                  o_v
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_done;
  logic                  r_z;
  logic                  r_n;
  logic                  r_v;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_accept;
  logic                  w_mul_last;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_fin_valid;
  logic [DATA_WIDTH-1:0] w_fin_result;
  logic                  w_fin_v;

  assign w_accept   = i_start && (r_state == S_IDLE);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_sum      = i_src1 + i_src2;
  assign w_diff     = i_src1 - i_src2;

  // Next-state logic for the multiplier sequencer.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept && (i_op == ALU_MUL)) w_state_next = S_MUL;
      S_MUL:  if (w_mul_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Completion: either a single-cycle op accepted now, or the final
  // multiply step. Overflow: operands agree in sign (ADD) or differ (SUB)
  // and the result sign differs from src1.
  always_comb begin
    w_fin_valid  = 1'b0;
    w_fin_result = '0;
    w_fin_v      = 1'b0;
    if (w_accept) begin
      unique case (i_op)
        ALU_PASS: begin
          w_fin_valid  = 1'b1;
          w_fin_result = i_src1;
        end
        ALU_ADD: begin
          w_fin_valid  = 1'b1;
          w_fin_result = w_sum;
          w_fin_v      = (i_src1[DATA_WIDTH-1] == i_src2[DATA_WIDTH-1]) &&
                         (w_sum[DATA_WIDTH-1] != i_src1[DATA_WIDTH-1]);
        end
        ALU_SUB: begin
          w_fin_valid  = 1'b1;
          w_fin_result = w_diff;
          w_fin_v      = (i_src1[DATA_WIDTH-1] != i_src2[DATA_WIDTH-1]) &&
                         (w_diff[DATA_WIDTH-1] != i_src1[DATA_WIDTH-1]);
        end
        default: ;  // ALU_MUL completes later through w_mul_last
      endcase
    end else if (w_mul_last) begin
      w_fin_valid  = 1'b1;
      w_fin_result = w_acc_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_result <= '0;
      r_done   <= 1'b0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= w_fin_valid;
      if (w_fin_valid) begin
        r_result <= w_fin_result;
        r_z      <= (w_fin_result == '0);
        r_n      <= w_fin_result[DATA_WIDTH-1];
        r_v      <= w_fin_v;
      end
      // Operands are private copies, so register writes during a multiply
      // cannot disturb it. Only the low DATA_WIDTH product bits are kept.
      if (w_accept && (i_op == ALU_MUL)) begin
        r_mcand  <= i_src1;
        r_mplier <= i_src2;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_result = r_result;
  assign o_busy   = (r_state == S_MUL);
  assign o_done   = r_done;
  assign o_z      = r_z;
  assign o_n      = r_n;
  assign o_v      = r_v;

endmodule

// File: rtl/datapath_param.sv
// -----------------------------------------------------------------------------
// datapath_param
// Parametrised processor datapath: instruction register, program counter,
// register file (two combinational read ports, one write port), register
// write-data and memory-address steering, and the sequential ALU (alu_seq).
//
// Ports:
//   Clk, Rst              clock; synchronous active-high reset
//   PC_Clr/Load/Cond/Inc  PC control (Clr > Load > Inc; Cond gates Load on Z)
//   IR_Load               latch Ram_Inst_Out into IR
//   Reg_Load              write register[Dest]
//   Alu_Op, Alu_Start     ALU operation and start strobe
//   Ram_Data_Read, Load_I register write source select (Load_I wins)
//   Load_M                Ram_Addr = Source1 instead of PC
//   Ram_Inst_Out/Data_Out instruction / data from memory
//   Opcode                IR opcode field
//   Ram_Addr, Ram_Data_In memory address, store data (= register[Source2])
//   Alu_Busy, Alu_Done    multiply in progress; completion pulse
//   Z_Flag, N_Flag, V_Flag ALU status flags
// -----------------------------------------------------------------------------
module datapath_param
  import dp_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int INST_WIDTH   = OPCODE_WIDTH + 3 * ADDR_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    PC_Clr,
  input  logic                    PC_Load,
  input  logic                    PC_Cond,
  input  logic                    PC_Inc,
  input  logic                    IR_Load,
  input  logic                    Reg_Load,
  input  logic [1:0]              Alu_Op,
  input  logic                    Alu_Start,
  input  logic                    Ram_Data_Read,
  input  logic                    Load_M,
  input  logic                    Load_I,
  input  logic [INST_WIDTH-1:0]   Ram_Inst_Out,
  input  logic [DATA_WIDTH-1:0]   Ram_Data_Out,
  output logic [OPCODE_WIDTH-1:0] Opcode,
  output logic [ADDR_WIDTH-1:0]   Ram_Addr,
  output logic [DATA_WIDTH-1:0]   Ram_Data_In,
  output logic                    Alu_Busy,
  output logic                    Alu_Done,
  output logic                    Z_Flag,
  output logic                    N_Flag,
  output logic                    V_Flag
);

  localparam int RIW      = reg_idx_width(NUM_REGS);
  localparam int SRC2_LSB = src2_lsb(ADDR_WIDTH);
  localparam int SRC1_LSB = src1_lsb(ADDR_WIDTH);
  localparam int OPC_LSB  = opcode_lsb(ADDR_WIDTH);

  logic [INST_WIDTH-1:0] r_ir;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] w_src1_field;
  logic [ADDR_WIDTH-1:0] w_src2_field;
  logic [ADDR_WIDTH-1:0] w_dest_field;
  logic [RIW-1:0]        w_src1_idx;
  logic [RIW-1:0]        w_src2_idx;
  logic [RIW-1:0]        w_dest_idx;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_z;
  logic                  w_unused_src2_hi;

  assign w_src1_field = r_ir[SRC1_LSB +: ADDR_WIDTH];
  assign w_src2_field = r_ir[SRC2_LSB +: ADDR_WIDTH];
  assign w_dest_field = r_ir[DEST_LSB +: ADDR_WIDTH];
  assign w_src1_idx   = w_src1_field[RIW-1:0];
  assign w_src2_idx   = w_src2_field[RIW-1:0];
  assign w_dest_idx   = w_dest_field[RIW-1:0];
  // Source2 only ever selects a register; its upper bits carry no meaning.
  assign w_unused_src2_hi = ^w_src2_field;

  always_ff @(posedge Clk) begin
    if (Rst)          r_ir <= '0;
    else if (IR_Load) r_ir <= Ram_Inst_Out;
  end

  // A conditional load that fails still claims the cycle, so PC_Inc is
  // ignored rather than falling through.
  always_ff @(posedge Clk) begin
    if (Rst)         r_pc <= '0;
    else if (PC_Clr) r_pc <= '0;
    else if (PC_Load) begin
      if (!PC_Cond || w_z) r_pc <= w_dest_field;
    end
    else if (PC_Inc) r_pc <= r_pc + ADDR_WIDTH'(1);
  end

  assign w_wr_data = Load_I        ? DATA_WIDTH'(w_src1_field) :
                     Ram_Data_Read ? Ram_Data_Out              :
                                     w_alu_result;

  always_ff @(posedge Clk) begin
    // NOTE: the register file must read as zero after reset, so it is built
    // from resettable flops rather than left to a RAM macro.
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (Reg_Load) begin
      r_regs[w_dest_idx] <= w_wr_data;
    end
  end

  // Read ports see only the registered contents: no write bypass.
  assign w_rd1 = r_regs[w_src1_idx];
  assign w_rd2 = r_regs[w_src2_idx];

  alu_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_start  (Alu_Start),
    .i_op     (alu_op_e'(Alu_Op)),
    .i_src1   (w_rd1),
    .i_src2   (w_rd2),
    .o_result (w_alu_result),
    .o_busy   (Alu_Busy),
    .o_done   (Alu_Done),
    .o_z      (w_z),
    .o_n      (N_Flag),
    .o_v      (V_Flag)
  );

  assign Z_Flag      = w_z;
  assign Opcode      = r_ir[OPC_LSB +: OPCODE_WIDTH];
  assign Ram_Addr    = Load_M ? w_src1_field : r_pc;
  assign Ram_Data_In = w_rd2;

endmodule

// File: tb/tb_datapath_param.sv
// -----------------------------------------------------------------------------
// tb_datapath_param
// Self-checking bench for datapath_param (default parameters). A register
// model supplies ALU operands; every accepted Alu_Start pushes its expected
// flags onto a queue that a negedge monitor pops on each Alu_Done. Results
// are observed by writing them back to a register and reading Ram_Data_In.
// -----------------------------------------------------------------------------
module tb_datapath_param;
  import dp_pkg::*;

  typedef struct {
    logic  z;
    logic  n;
    logic  v;
    string tag;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst, PC_Clr, PC_Load, PC_Cond, PC_Inc, IR_Load, Reg_Load;
  logic [1:0]  Alu_Op;
  logic        Alu_Start, Ram_Data_Read, Load_M, Load_I;
  logic [27:0] Ram_Inst_Out;
  logic [15:0] Ram_Data_Out;
  logic [3:0]  Opcode;
  logic [7:0]  Ram_Addr;
  logic [15:0] Ram_Data_In;
  logic        Alu_Busy, Alu_Done, Z_Flag, N_Flag, V_Flag;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  exp_t        exp_q[$];
  logic [15:0] m_regs [16];

  datapath_param dut (
    .Clk(Clk), .Rst(Rst), .PC_Clr(PC_Clr), .PC_Load(PC_Load),
    .PC_Cond(PC_Cond), .PC_Inc(PC_Inc), .IR_Load(IR_Load),
    .Reg_Load(Reg_Load), .Alu_Op(Alu_Op), .Alu_Start(Alu_Start),
    .Ram_Data_Read(Ram_Data_Read), .Load_M(Load_M), .Load_I(Load_I),
    .Ram_Inst_Out(Ram_Inst_Out), .Ram_Data_Out(Ram_Data_Out),
    .Opcode(Opcode), .Ram_Addr(Ram_Addr), .Ram_Data_In(Ram_Data_In),
    .Alu_Busy(Alu_Busy), .Alu_Done(Alu_Done), .Z_Flag(Z_Flag),
    .N_Flag(N_Flag), .V_Flag(V_Flag)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard monitor: each Done pulse retires the oldest expectation.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Alu_Done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(Alu_Done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_z"}, 32'(Z_Flag), 32'(e.z));
        check({e.tag, "_n"}, 32'(N_Flag), 32'(e.n));
        check({e.tag, "_v"}, 32'(V_Flag), 32'(e.v));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctrl();
    PC_Clr = 0; PC_Load = 0; PC_Cond = 0; PC_Inc = 0; IR_Load = 0;
    Reg_Load = 0; Alu_Op = 2'd0; Alu_Start = 0; Ram_Data_Read = 0;
    Load_M = 0; Load_I = 0;
  endtask

  task automatic do_reset();
    Rst = 1;
    tick();
    tick();
    Rst = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
  endtask

  task automatic load_ir(input int opc, input int s1, input int s2, input int d);
    Ram_Inst_Out = {4'(opc), 8'(s1), 8'(s2), 8'(d)};
    IR_Load = 1;
    tick();
    IR_Load = 0;
  endtask

  task automatic write_imm(input int d, input int val);
    load_ir(0, val, 0, d);
    Load_I = 1; Reg_Load = 1;
    tick();
    Load_I = 0; Reg_Load = 0;
    m_regs[d & 15] = 16'(val & 8'hFF);
  endtask

  task automatic write_ram(input int d, input logic [15:0] val);
    load_ir(0, 0, 0, d);
    Ram_Data_Out = val; Ram_Data_Read = 1; Reg_Load = 1;
    tick();
    Ram_Data_Read = 0; Reg_Load = 0;
    m_regs[d & 15] = val;
  endtask

  task automatic read_reg(input string tag, input int idx, input logic [15:0] exp);
    load_ir(0, 0, idx, 0);
    check(tag, 32'(Ram_Data_In), 32'(exp));
  endtask

  // Issue an ALU op; the expectation is computed from the register model.
  task automatic alu(input string tag, input alu_op_e op, input int s1, input int s2,
                     input int d, output logic [15:0] res);
    logic [15:0] a, b;
    logic [31:0] prod;
    int          sa, sb, full;
    exp_t        e;
    load_ir(0, s1, s2, d);
    a = m_regs[s1 & 15];
    b = m_regs[s2 & 15];
    sa = $signed(a);
    sb = $signed(b);
    e.v = 1'b0;
    case (op)
      ALU_PASS: res = a;
      ALU_ADD: begin
        full = sa + sb;
        res  = 16'(full);
        e.v  = (full > 32767) || (full < -32768);
      end
      ALU_SUB: begin
        full = sa - sb;
        res  = 16'(full);
        e.v  = (full > 32767) || (full < -32768);
      end
      default: begin
        prod = 32'(a) * 32'(b);
        res  = prod[15:0];
      end
    endcase
    e.z = (res == 16'h0);
    e.n = res[15];
    e.tag = tag;
    exp_q.push_back(e);
    Alu_Op = op; Alu_Start = 1;
    tick();
    Alu_Start = 0;
  endtask

  // Write the current ALU result into register d (IR Dest must be d).
  task automatic store_result(input int d, input logic [15:0] res);
    Reg_Load = 1;
    tick();
    Reg_Load = 0;
    m_regs[d & 15] = res;
  endtask

  task automatic wait_mul(input string tag);
    int n = 0;
    while (Alu_Busy === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    check(tag, 32'(n), 32'd16);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] res;
    int          n;
    int          done_snap;
    clear_ctrl();
    Ram_Inst_Out = '0;
    Ram_Data_Out = '0;
    do_reset();

    check("rst_opcode", 32'(Opcode), 32'd0);
    check("rst_ram_addr", 32'(Ram_Addr), 32'd0);
    check("rst_data_in", 32'(Ram_Data_In), 32'd0);
    check("rst_busy", 32'(Alu_Busy), 32'd0);
    check("rst_done", 32'(Alu_Done), 32'd0);
    check("rst_flags", 32'({Z_Flag, N_Flag, V_Flag}), 32'd0);

    // Immediate loads and register read-back.
    load_ir(3, 8'h05, 0, 2);
    check("ir_opcode", 32'(Opcode), 32'd3);
    Load_I = 1; Reg_Load = 1;
    tick();
    Load_I = 0; Reg_Load = 0;
    m_regs[2] = 16'd5;
    load_ir(3, 8'h07, 0, 1);
    Load_M = 1;
    #1 check("load_m_addr", 32'(Ram_Addr), 32'h07);
    Load_M = 0;
    Load_I = 1; Reg_Load = 1;
    tick();
    Load_I = 0; Reg_Load = 0;
    m_regs[1] = 16'd7;
    read_reg("r2_imm", 2, 16'd5);
    read_reg("r1_imm", 1, 16'd7);

    // Write-source priority: Load_I beats Ram_Data_Read.
    load_ir(0, 8'h33, 0, 5);
    Load_I = 1; Ram_Data_Read = 1; Ram_Data_Out = 16'hBEEF; Reg_Load = 1;
    tick();
    Load_I = 0; Ram_Data_Read = 0; Reg_Load = 0;
    m_regs[5] = 16'h0033;
    read_reg("load_i_priority", 5, 16'h0033);
    write_ram(4, 16'hBEEF);
    read_reg("ram_data_write", 4, 16'hBEEF);

    // ADD 5 + 7.
    alu("add", ALU_ADD, 2, 1, 3, res);
    store_result(3, res);
    check("done_one_cycle", 32'(Alu_Done), 32'd0);
    read_reg("add_result", 3, 16'd12);

    // Signed overflow on ADD and SUB.
    write_ram(9, 16'h7FFF);
    write_imm(10, 1);
    alu("add_ovf", ALU_ADD, 9, 10, 11, res);
    store_result(11, res);
    read_reg("add_ovf_result", 11, 16'h8000);
    alu("sub_ovf", ALU_SUB, 11, 10, 12, res);
    store_result(12, res);
    read_reg("sub_ovf_result", 12, 16'h7FFF);

    // SUB 7 - 7 -> zero.
    write_imm(2, 7);
    alu("sub_zero", ALU_SUB, 2, 1, 3, res);
    store_result(3, res);
    read_reg("sub_result", 3, 16'd0);

    // MUL 5 * 7 with an ignored restart and an operand write mid-flight.
    write_imm(2, 5);
    alu("mul_35", ALU_MUL, 2, 1, 2, res);
    done_snap = done_cnt;
    n = 0;
    while (Alu_Busy === 1'b1 && n < 64) begin
      n++;
      if (n == 3) begin
        Alu_Op = ALU_ADD; Alu_Start = 1;
      end
      if (n == 5) begin
        Ram_Data_Out = 16'h1234; Ram_Data_Read = 1; Reg_Load = 1;
        m_regs[2] = 16'h1234;
      end
      tick();
      Alu_Start = 0; Ram_Data_Read = 0; Reg_Load = 0;
    end
    check("mul_busy_cycles", 32'(n), 32'd16);
    store_result(2, res);
    check("mul_done_once", 32'(done_cnt - done_snap), 32'd1);
    read_reg("mul_result", 2, 16'd35);

    // MUL 0xFFFF * 2.
    write_ram(6, 16'hFFFF);
    write_imm(7, 2);
    alu("mul_neg", ALU_MUL, 6, 7, 8, res);
    wait_mul("mul_neg_busy");
    store_result(8, res);
    read_reg("mul_neg_result", 8, 16'hFFFE);

    // PC: load, wrap, conditional hold/take, priority.
    load_ir(0, 0, 0, 8'hFF);
    PC_Load = 1;
    tick();
    PC_Load = 0;
    check("pc_load", 32'(Ram_Addr), 32'hFF);
    PC_Inc = 1;
    tick();
    check("pc_wrap", 32'(Ram_Addr), 32'h00);
    tick();
    PC_Inc = 0;
    check("pc_inc", 32'(Ram_Addr), 32'h01);
    check("z_before_cond", 32'(Z_Flag), 32'd0);
    load_ir(0, 0, 0, 8'h40);
    PC_Load = 1; PC_Cond = 1; PC_Inc = 1;
    tick();
    clear_ctrl();
    check("pc_cond_hold", 32'(Ram_Addr), 32'h01);
    alu("pass_zero", ALU_PASS, 0, 0, 8'h40, res);
    PC_Load = 1; PC_Cond = 1;
    tick();
    clear_ctrl();
    check("pc_cond_take", 32'(Ram_Addr), 32'h40);
    PC_Inc = 1;
    tick();
    PC_Clr = 1; PC_Load = 1;
    tick();
    clear_ctrl();
    check("pc_clr_priority", 32'(Ram_Addr), 32'h00);
    PC_Load = 1; PC_Inc = 1;
    tick();
    clear_ctrl();
    check("pc_load_over_inc", 32'(Ram_Addr), 32'h40);

    // Reset five cycles into a multiply.
    alu("mul_aborted", ALU_MUL, 2, 1, 3, res);
    for (int i = 0; i < 4; i++) tick();
    done_snap = done_cnt;
    do_reset();
    tick();
    tick();
    check("abort_busy", 32'(Alu_Busy), 32'd0);
    check("abort_no_done", 32'(done_cnt - done_snap), 32'd0);
    check("abort_flags", 32'({Z_Flag, N_Flag, V_Flag}), 32'd0);
    check("abort_pc", 32'(Ram_Addr), 32'd0);
    read_reg("abort_r1", 1, 16'd0);
    read_reg("abort_r2", 2, 16'd0);

    // A fresh multiply after the abort.
    write_imm(1, 3);
    write_imm(2, 200);
    done_snap = done_cnt;
    alu("mul_after_rst", ALU_MUL, 2, 1, 4, res);
    wait_mul("mul_after_rst_busy");
    store_result(4, res);
    check("mul_after_rst_done", 32'(done_cnt - done_snap), 32'd1);
    read_reg("mul_after_rst_result", 4, 16'd600);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
